// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ASIP pipeline: operand forwarding, load-use
// stalls, taken-branch flushes and the stall/bubble sequence around the multi-cycle unit in EX.
module pipe_hazard_ctrl #(
    parameter int unsigned RW_W       = 5,
    parameter int unsigned MC_MAX_CYC = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RW_W-1:0] rs1_id,
    input  logic [RW_W-1:0] rs2_id,
    input  logic [RW_W-1:0] rs1_ex,
    input  logic [RW_W-1:0] rs2_ex,
    input  logic [RW_W-1:0] rw_ex,
    input  logic            wr_en_ex,
    input  logic            wd_sel_ex,
    input  logic [RW_W-1:0] rw_mem,
    input  logic            wr_en_mem,
    input  logic [RW_W-1:0] rw_wb,
    input  logic            wr_en_wb,
    input  logic            branch_taken_ex,
    input  logic            mc_start_ex,
    input  logic            mc_done,
    output logic            mc_req,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            flush_mem,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mc_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mc_req_q;
    logic             mc_timeout_q;
    logic             load_use;
    logic             mc_hold;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [RW_W-1:0] src,
        input logic [RW_W-1:0] dst_mem,
        input logic            en_mem,
        input logic [RW_W-1:0] dst_wb,
        input logic            en_wb
    );
        if (src == '0)                    return 2'b00;
        else if (en_mem && dst_mem == src) return 2'b01;
        else if (en_wb && dst_wb == src)   return 2'b10;
        else                               return 2'b00;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mc_req_q     <= 1'b0;
            mc_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mc_req_q <= 1'b0;
                    if (mc_start_ex) begin
                        state_q  <= BUSY;
                        cnt_q    <= '0;
                        mc_req_q <= 1'b1;
                    end
                end
                BUSY: begin
                    mc_req_q <= 1'b0;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mc_done) begin
                        state_q <= DONE;
                    end else if (cnt_q == CNT_W'(MC_MAX_CYC - 1)) begin
                        mc_timeout_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    mc_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    mc_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mc_req     = mc_req_q;
    assign mc_timeout = mc_timeout_q;

    assign load_use = wr_en_ex && wd_sel_ex && (rw_ex != '0) &&
                      ((rw_ex == rs1_id) || (rw_ex == rs2_id));
    assign mc_hold  = (state_q == BUSY) || ((state_q == IDLE) && mc_start_ex);

    // Priority: multi-cycle sequencing, then branch flush, then load-use bubble.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        if (!reset) begin
            fwd_a = fwd_sel(rs1_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb);
            fwd_b = fwd_sel(rs2_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb);
            if (mc_hold) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
            end else if ((state_q == IDLE) && branch_taken_ex) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if ((state_q == IDLE) && load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    a_no_mc_with_branch: assert property (@(posedge clock) disable iff (reset)
        !(mc_start_ex && branch_taken_ex));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by randomized
// traffic, every output compared each cycle against a behavioural model of the pipeline rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MAXC = 12;

    logic       clock;
    logic       reset;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rw_ex, rw_mem, rw_wb;
    logic       wr_en_ex, wd_sel_ex, wr_en_mem, wr_en_wb;
    logic       branch_taken_ex, mc_start_ex, mc_done;
    logic       mc_req, stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mc_timeout;
    logic [1:0] fwd_a, fwd_b;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = idle, 1 = multi-cycle op running, 2 = result-capture cycle.
    int m_ph;
    int m_busy_n;
    bit m_req;
    bit m_to;

    logic seen_stall, seen_req;

    pipe_hazard_ctrl #(.RW_W(5), .MC_MAX_CYC(MAXC), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rw_ex(rw_ex), .wr_en_ex(wr_en_ex), .wd_sel_ex(wd_sel_ex),
        .rw_mem(rw_mem), .wr_en_mem(wr_en_mem), .rw_wb(rw_wb), .wr_en_wb(wr_en_wb),
        .branch_taken_ex(branch_taken_ex), .mc_start_ex(mc_start_ex), .mc_done(mc_done),
        .mc_req(mc_req), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_timeout(mc_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (reset || src == 5'd0)             return 2'b00;
        if (wr_en_mem && rw_mem == src)        return 2'b01;
        if (wr_en_wb && rw_wb == src)          return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        reset = 1'b0;
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rw_ex, rw_mem, rw_wb} = '0;
        {wr_en_ex, wd_sel_ex, wr_en_mem, wr_en_wb} = '0;
        {branch_taken_ex, mc_start_ex, mc_done} = '0;
    endtask

    // Inputs are already driven; check outputs mid-cycle, then advance the model over the edge.
    task automatic cycle();
        bit idle, hold, lu, e_br, e_lu;
        #3;
        idle = (m_ph == 0);
        hold = !reset && (m_ph == 1 || (idle && mc_start_ex));
        lu   = wr_en_ex && wd_sel_ex && rw_ex != 5'd0 && (rw_ex == rs1_id || rw_ex == rs2_id);
        e_br = !reset && idle && !mc_start_ex && branch_taken_ex;
        e_lu = !reset && idle && !mc_start_ex && !branch_taken_ex && lu;
        chk("stall_if",   {1'b0, stall_if},   {1'b0, hold || e_lu});
        chk("stall_id",   {1'b0, stall_id},   {1'b0, hold || e_lu});
        chk("stall_ex",   {1'b0, stall_ex},   {1'b0, hold});
        chk("flush_id",   {1'b0, flush_id},   {1'b0, e_br});
        chk("flush_ex",   {1'b0, flush_ex},   {1'b0, e_br || e_lu});
        chk("flush_mem",  {1'b0, flush_mem},  {1'b0, hold});
        chk("fwd_a",      fwd_a,              exp_fwd(rs1_ex));
        chk("fwd_b",      fwd_b,              exp_fwd(rs2_ex));
        chk("mc_req",     {1'b0, mc_req},     {1'b0, m_req});
        chk("mc_timeout", {1'b0, mc_timeout}, {1'b0, m_to});
        seen_stall = stall_if;
        seen_req   = mc_req;
        @(posedge clock);
        if (reset) begin
            m_ph = 0; m_busy_n = 0; m_req = 0; m_to = 0;
        end else if (m_ph == 0) begin
            m_req = mc_start_ex;
            if (mc_start_ex) begin m_ph = 1; m_busy_n = 0; end
        end else if (m_ph == 1) begin
            m_req = 0;
            m_busy_n++;
            if (mc_done) m_ph = 2;
            else if (m_busy_n == MAXC) begin m_to = 1; m_ph = 2; end
        end else begin
            m_req = 0;
            m_ph  = 0;
        end
        #1;
    endtask

    initial begin
        int n_stall, n_req;
        clear_inputs();
        reset = 1'b1;
        m_ph = 0; m_busy_n = 0; m_req = 0; m_to = 0;
        @(posedge clock);
        #1;
        // Reset held: registered flags already cleared, combinational outputs forced low.
        reset = 1'b1; mc_start_ex = 1'b1; rs1_ex = 5'd3; rw_mem = 5'd3; wr_en_mem = 1'b1;
        cycle();
        clear_inputs();

        // Forwarding priority and x0.
        rw_mem = 5'd3; wr_en_mem = 1'b1; rw_wb = 5'd3; wr_en_wb = 1'b1; rs1_ex = 5'd3;
        cycle();
        chk("dir_fwd_mem_beats_wb", fwd_a, 2'b01);
        rs1_ex = 5'd0;
        cycle();
        chk("dir_fwd_x0", fwd_a, 2'b00);
        wr_en_mem = 1'b0; rs2_ex = 5'd3;
        cycle();
        chk("dir_fwd_wb", fwd_b, 2'b10);
        clear_inputs();

        // Load-use bubble, then clear.
        rw_ex = 5'd5; wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rs2_id = 5'd5;
        cycle();
        chk("dir_lu_stall", {1'b0, seen_stall}, 2'b01);
        clear_inputs();
        cycle();
        chk("dir_lu_gone", {1'b0, seen_stall}, 2'b00);

        // Branch overrides load-use.
        rw_ex = 5'd5; wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rs1_id = 5'd5; branch_taken_ex = 1'b1;
        cycle();
        chk("dir_br_no_stall", {1'b0, seen_stall}, 2'b00);
        clear_inputs();

        // Multi-cycle op with mc_done on the 10th busy cycle.
        n_stall = 0; n_req = 0;
        for (int i = 0; i < 12; i++) begin
            mc_start_ex = (i == 0);
            mc_done     = (i == 10);
            cycle();
            n_stall += int'(seen_stall);
            n_req   += int'(seen_req);
        end
        chk("dir_mc_stall_cycles", 2'(n_stall == 11), 2'b01);
        chk("dir_mc_req_pulses",   2'(n_req == 1),    2'b01);
        clear_inputs();

        // Watchdog: mc_done never arrives.
        mc_start_ex = 1'b1;
        cycle();
        mc_start_ex = 1'b0;
        for (int i = 0; i < int'(MAXC) + 4; i++) cycle();
        chk("dir_timeout_sticky", {1'b0, mc_timeout}, 2'b01);

        // Reset in the middle of an op.
        mc_start_ex = 1'b1;
        cycle();
        mc_start_ex = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("dir_rst_busy_timeout", {1'b0, mc_timeout}, 2'b00);
        chk("dir_rst_busy_stall",   {1'b0, seen_stall}, 2'b00);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(59) == 0);
            rs1_id      = 5'($urandom_range(7));
            rs2_id      = 5'($urandom_range(7));
            rs1_ex      = 5'($urandom_range(7));
            rs2_ex      = 5'($urandom_range(7));
            rw_ex       = 5'($urandom_range(7));
            rw_mem      = 5'($urandom_range(7));
            rw_wb       = 5'($urandom_range(7));
            wr_en_ex    = 1'($urandom_range(1));
            wd_sel_ex   = 1'($urandom_range(1));
            wr_en_mem   = 1'($urandom_range(1));
            wr_en_wb    = 1'($urandom_range(1));
            mc_start_ex = ($urandom_range(5) == 0);
            branch_taken_ex = mc_start_ex ? 1'b0 : ($urandom_range(3) == 0);
            mc_done     = ($urandom_range(9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
